// File: rtl/wb_host_arbiter.sv
// Two-master Wishbone arbiter in front of a single slave bus, with fair alternation
// on contention and a watchdog that terminates strobes the slave never acknowledges.
module wb_host_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       lastOwner_q, lastOwner_d;
    logic [9:0] tmoCnt_q, tmoCnt_d;

    logic        own0, own1, owning;
    logic        tmoHit;
    logic        ownerAck;
    logic [31:0] ownerDat;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            lastOwner_q <= 1'b1;
            tmoCnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            tmoCnt_q    <= tmoCnt_d;
        end
    end

    // On contention the master that was not served last wins; lastOwner is recorded on release.
    always_comb begin
        state_d     = state_q;
        lastOwner_d = lastOwner_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = lastOwner_q ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_d = OWN0;
                end else if (m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_d     = IDLE;
                    lastOwner_d = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_d     = IDLE;
                    lastOwner_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign own0    = (state_q == OWN0);
    assign own1    = (state_q == OWN1);
    assign owning  = own0 | own1;
    assign grant_o = {own1, own0};

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // A genuine slave ack in the final wait cycle takes priority over the forced termination.
    assign tmoHit    = owning && s_stb_o && !s_ack_i && (tmoCnt_q == TMO_LAST);
    assign timeout_o = tmoHit;
    assign ownerAck  = owning && (s_ack_i || tmoHit);
    assign ownerDat  = tmoHit ? ERR_DATA : s_dat_i;

    assign m0_ack_o = own0 && ownerAck;
    assign m1_ack_o = own1 && ownerAck;
    assign m0_dat_o = own0 ? ownerDat : '0;
    assign m1_dat_o = own1 ? ownerDat : '0;

    always_comb begin
        tmoCnt_d = tmoCnt_q + 10'd1;
        if (!owning || !s_stb_o || s_ack_i || tmoHit) begin
            tmoCnt_d = '0;
        end
    end

endmodule

// File: tb/tb_wb_host_arbiter.sv
// Randomized and directed bench for wb_host_arbiter: a transaction-level arbitration model
// predicts every cycle's outputs into a queue that an independent monitor drains and compares.
module tb_wb_host_arbiter;

    localparam int unsigned TB_TIMEOUT = 255;
    localparam logic [31:0] TB_ERR     = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } mreq_t;

    typedef struct packed {
        logic [1:0]  grant;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        ack0;
        logic [31:0] dat0;
        logic        ack1;
        logic [31:0] dat1;
        logic        tmo;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        m0Cyc, m0Stb, m0We, m0Ack;
    logic [3:0]  m0Sel;
    logic [31:0] m0Adr, m0DatIn, m0DatOut;
    logic        m1Cyc, m1Stb, m1We, m1Ack;
    logic [3:0]  m1Sel;
    logic [31:0] m1Adr, m1DatIn, m1DatOut;
    logic        sCyc, sStb, sWe, sAck;
    logic [3:0]  sSel;
    logic [31:0] sAdr, sDatOut, sDatIn;
    logic [1:0]  grant;
    logic        timeoutPulse;

    int   compared   = 0;
    int   mismatched = 0;
    int   cycleNo    = 0;
    exp_t expQ[$];

    // Reference model state: who owns the bus, who was served last, how long the strobe has waited.
    int owner      = -1;
    int lastServed = 1;
    int waitCycles = 0;

    wb_host_arbiter #(
        .TIMEOUT  (TB_TIMEOUT),
        .ERR_DATA (TB_ERR)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rstN),
        .m0_cyc_i   (m0Cyc),
        .m0_stb_i   (m0Stb),
        .m0_we_i    (m0We),
        .m0_sel_i   (m0Sel),
        .m0_adr_i   (m0Adr),
        .m0_dat_i   (m0DatIn),
        .m0_ack_o   (m0Ack),
        .m0_dat_o   (m0DatOut),
        .m1_cyc_i   (m1Cyc),
        .m1_stb_i   (m1Stb),
        .m1_we_i    (m1We),
        .m1_sel_i   (m1Sel),
        .m1_adr_i   (m1Adr),
        .m1_dat_i   (m1DatIn),
        .m1_ack_o   (m1Ack),
        .m1_dat_o   (m1DatOut),
        .s_cyc_o    (sCyc),
        .s_stb_o    (sStb),
        .s_we_o     (sWe),
        .s_sel_o    (sSel),
        .s_adr_o    (sAdr),
        .s_dat_o    (sDatOut),
        .s_ack_i    (sAck),
        .s_dat_i    (sDatIn),
        .grant_o    (grant),
        .timeout_o  (timeoutPulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic mreq_t mk(input logic cyc, input logic stb, input logic we,
                                 input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        mreq_t r;
        r.cyc = cyc; r.stb = stb; r.we = we; r.sel = sel; r.adr = adr; r.dat = dat;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cycleNo, act, exp);
        end
    endtask

    task automatic driveInputs(input mreq_t a, input mreq_t b, input logic ack, input logic [31:0] sdat);
        m0Cyc = a.cyc; m0Stb = a.stb; m0We = a.we; m0Sel = a.sel; m0Adr = a.adr; m0DatIn = a.dat;
        m1Cyc = b.cyc; m1Stb = b.stb; m1We = b.we; m1Sel = b.sel; m1Adr = b.adr; m1DatIn = b.dat;
        sAck = ack; sDatIn = sdat;
    endtask

    // One bus cycle: drive inputs, predict this cycle's outputs, then advance the model to the next edge.
    task automatic applyStimulus(input mreq_t a, input mreq_t b, input logic ack, input logic [31:0] sdat);
        exp_t  e;
        mreq_t req [2];
        logic  timedOut, giveAck;
        logic [31:0] data;
        @(posedge clk);
        #1;
        driveInputs(a, b, ack, sdat);
        e = '0;
        req[0] = a;
        req[1] = b;
        if (owner >= 0) begin
            e.grant  = (owner == 0) ? 2'b01 : 2'b10;
            e.cyc    = req[owner].cyc;
            e.stb    = req[owner].stb;
            e.we     = req[owner].we;
            e.sel    = req[owner].sel;
            e.adr    = req[owner].adr;
            e.dat    = req[owner].dat;
            timedOut = req[owner].stb && !ack && (waitCycles == int'(TB_TIMEOUT) - 1);
            giveAck  = ack || timedOut;
            data     = timedOut ? TB_ERR : sdat;
            if (owner == 0) begin
                e.ack0 = giveAck; e.dat0 = data;
            end else begin
                e.ack1 = giveAck; e.dat1 = data;
            end
            e.tmo = timedOut;
            if (req[owner].stb && !giveAck) waitCycles++;
            else waitCycles = 0;
            if (!req[owner].cyc) begin
                lastServed = owner;
                owner      = -1;
            end
        end else begin
            waitCycles = 0;
            if (a.cyc && b.cyc) owner = 1 - lastServed;
            else if (a.cyc) owner = 0;
            else if (b.cyc) owner = 1;
        end
        expQ.push_back(e);
    endtask

    // Asynchronous reset pulse with an immediate check that every output has collapsed to zero.
    task automatic resetDut();
        @(posedge clk);
        #2;
        rstN = 1'b0;
        sAck = 1'b1;
        sDatIn = 32'h1111_2222;
        #1;
        checkOutput("rst_grant",   32'(grant),        32'h0);
        checkOutput("rst_s_cyc",   32'(sCyc),         32'h0);
        checkOutput("rst_s_stb",   32'(sStb),         32'h0);
        checkOutput("rst_s_we",    32'(sWe),          32'h0);
        checkOutput("rst_s_sel",   32'(sSel),         32'h0);
        checkOutput("rst_s_adr",   sAdr,              32'h0);
        checkOutput("rst_s_dat",   sDatOut,           32'h0);
        checkOutput("rst_m0_ack",  32'(m0Ack),        32'h0);
        checkOutput("rst_m0_dat",  m0DatOut,          32'h0);
        checkOutput("rst_m1_ack",  32'(m1Ack),        32'h0);
        checkOutput("rst_m1_dat",  m1DatOut,          32'h0);
        checkOutput("rst_timeout", 32'(timeoutPulse), 32'h0);
        driveInputs('0, '0, 1'b0, 32'h0);
        @(posedge clk);
        #3;
        rstN       = 1'b1;
        owner      = -1;
        lastServed = 1;
        waitCycles = 0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("grant",   32'(grant),        32'(e.grant));
                checkOutput("s_cyc",   32'(sCyc),         32'(e.cyc));
                checkOutput("s_stb",   32'(sStb),         32'(e.stb));
                checkOutput("s_we",    32'(sWe),          32'(e.we));
                checkOutput("s_sel",   32'(sSel),         32'(e.sel));
                checkOutput("s_adr",   sAdr,              e.adr);
                checkOutput("s_dat",   sDatOut,           e.dat);
                checkOutput("m0_ack",  32'(m0Ack),        32'(e.ack0));
                checkOutput("m0_dat",  m0DatOut,          e.dat0);
                checkOutput("m1_ack",  32'(m1Ack),        32'(e.ack1));
                checkOutput("m1_dat",  m1DatOut,          e.dat1);
                checkOutput("timeout", 32'(timeoutPulse), 32'(e.tmo));
                cycleNo++;
            end
        end
    end

    initial begin
        mreq_t idle, wr, rdA, rdB, rd1, rnd [2];
        logic  silent;
        int    drain;
        idle = '0;
        rstN = 1'b0;
        driveInputs('0, '0, 1'b0, 32'h0);
        resetDut();

        // Single write from m0, slave acks two cycles after the strobe appears.
        wr = mk(1'b1, 1'b1, 1'b1, 4'hF, 32'h3000_0004, 32'h1234_5678);
        applyStimulus(wr, idle, 1'b0, 32'h0);
        applyStimulus(wr, idle, 1'b0, 32'h0);
        applyStimulus(wr, idle, 1'b1, 32'h0);
        applyStimulus(idle, idle, 1'b0, 32'h0);
        applyStimulus(idle, idle, 1'b0, 32'h0);

        // Simultaneous requests after reset: m0, bubble, m1, then m0 again.
        resetDut();
        rdA = mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0010, 32'h0);
        rdB = mk(1'b1, 1'b1, 1'b0, 4'h3, 32'h3000_0020, 32'h0);
        applyStimulus(rdA, rdB, 1'b0, 32'h0);
        applyStimulus(rdA, rdB, 1'b1, 32'hA0A0_0001);
        applyStimulus(idle, rdB, 1'b0, 32'h0);
        applyStimulus(idle, rdB, 1'b0, 32'h0);
        applyStimulus(idle, rdB, 1'b1, 32'hB0B0_0002);
        applyStimulus(idle, idle, 1'b0, 32'h0);
        applyStimulus(rdA, rdB, 1'b0, 32'h0);
        applyStimulus(rdA, rdB, 1'b1, 32'hA0A0_0003);
        applyStimulus(idle, rdB, 1'b0, 32'h0);
        applyStimulus(idle, rdB, 1'b1, 32'hB0B0_0004);
        applyStimulus(idle, idle, 1'b0, 32'h0);

        // m1 read against a silent slave: forced termination on the final wait cycle.
        rd1 = mk(1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0100, 32'h0);
        for (int i = 0; i < 262; i++) applyStimulus(idle, rd1, 1'b0, 32'h5555_0000 + 32'(i));
        applyStimulus(idle, idle, 1'b0, 32'h0);

        // Slave ack landing exactly on the timeout cycle wins over the forced termination.
        applyStimulus(rdA, idle, 1'b0, 32'h0);
        for (int i = 0; i < int'(TB_TIMEOUT) - 1; i++) applyStimulus(rdA, idle, 1'b0, 32'h0);
        applyStimulus(rdA, idle, 1'b1, 32'hCAFE_0001);
        applyStimulus(idle, idle, 1'b0, 32'h0);

        // m1 locks the bus for four acked beats while m0 waits.
        applyStimulus(idle, rdB, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) applyStimulus(rdA, rdB, 1'(i % 2), 32'hBEA7_0000 + 32'(i));
        applyStimulus(rdA, idle, 1'b1, 32'h0BAD_0BAD);
        applyStimulus(rdA, idle, 1'b1, 32'h0BAD_0BAD);
        applyStimulus(rdA, idle, 1'b1, 32'h0000_0A0A);
        applyStimulus(idle, idle, 1'b0, 32'h0);

        // Reset pulse while m0 waits for its ack, then a clean re-grant.
        applyStimulus(rdA, idle, 1'b0, 32'h0);
        applyStimulus(rdA, idle, 1'b0, 32'h0);
        applyStimulus(rdA, idle, 1'b0, 32'h0);
        resetDut();
        applyStimulus(rdA, idle, 1'b1, 32'h7777_0001);
        applyStimulus(rdA, idle, 1'b1, 32'h7777_0002);
        applyStimulus(idle, idle, 1'b0, 32'h0);

        // Randomized traffic; some blocks use a silent slave with long-held cycles.
        rnd[0] = '0;
        rnd[1] = '0;
        for (int blk = 0; blk < 6; blk++) begin
            silent = (blk % 3 == 2);
            for (int c = 0; c < 500; c++) begin
                for (int k = 0; k < 2; k++) begin
                    if (rnd[k].cyc) rnd[k].cyc = silent ? ($urandom_range(0, 999) < 998) : ($urandom_range(0, 99) < 85);
                    else rnd[k].cyc = ($urandom_range(0, 99) < 30);
                    rnd[k].stb = rnd[k].cyc ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0);
                    rnd[k].we  = 1'($urandom_range(0, 1));
                    rnd[k].sel = 4'($urandom_range(0, 15));
                    rnd[k].adr = $urandom();
                    rnd[k].dat = $urandom();
                end
                applyStimulus(rnd[0], rnd[1], silent ? 1'b0 : ($urandom_range(0, 3) == 0), $urandom());
            end
        end
        applyStimulus(idle, idle, 1'b0, 32'h0);
        applyStimulus(idle, idle, 1'b0, 32'h0);

        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #1;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expected cycles left, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
